separable_locking_allocator: RTL
================================

SEPARABLE_LOCKING_ALLOCATOR -- requirements
Module: separable_locking_allocator

Interface
REQ-001 SHALL have parameter IN_NUM, default 5, number of input ports.
REQ-002 SHALL have parameter OUT_NUM, default 5, number of output ports.
REQ-003 SHALL have parameter VC_NUM, default 2, VCs per input port; legal range 1..8.
REQ-004 SHALL have parameter LOCK_EN, default 1; 1 enables packet locking, 0 gives per-flit arbitration.
REQ-005 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: RST  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports: vc_request  input  [IN_NUM][VC_NUM]  VC requests allocation.
REQ-008 SHALL have ports: vc_target_port  input  [IN_NUM][VC_NUM] x $clog2(OUT_NUM)  requested output per VC.
REQ-009 SHALL have ports: vc_tail  input  [IN_NUM][VC_NUM]  flit on this VC is a packet tail (single-flit packets assert it).
REQ-010 SHALL have ports: out_ready  input  [OUT_NUM]  output can accept a flit this cycle (credit available).
REQ-011 SHALL have ports: vc_grant  output  [IN_NUM][VC_NUM]  registered grant, one-hot or zero per input.
REQ-012 SHALL have ports: out_valid  output  [OUT_NUM]  registered, output granted this cycle.
REQ-013 SHALL have ports: out_sel_in  output  [OUT_NUM] x $clog2(IN_NUM)  registered winning input index per output; 0 when out_valid=0.
REQ-014 SHALL have ports: out_locked  output  [OUT_NUM]  registered, output currently held by an open packet.

Function
REQ-015 SHALL treat VC (i,v) as eligible when vc_request=1, target<OUT_NUM, out_ready[target]=1, and no lock blocks it (REQ-021, REQ-022).
REQ-016 SHALL run stage 1 per input: round-robin among eligible VCs from in_ptr[i], selecting at most one VC.
REQ-017 SHALL run stage 2 per output: round-robin among inputs whose stage-1 VC targets it, from out_ptr[o], selecting at most one input.
REQ-018 SHALL register the stage-2 results so that vc_grant, out_valid and out_sel_in appear exactly 1 cycle after the sampled inputs.
REQ-019 SHALL update pointers iSLIP-style: in_ptr[i] and out_ptr[o] advance to (winner+1) mod size only on a final grant; losing stage-1 selections leave in_ptr unchanged.
REQ-020 SHALL, with LOCK_EN=1, on a final grant with vc_tail=0 record lock (o -> i,v) and assert out_locked[o] next cycle.
REQ-021 SHALL, while output o is locked to (i,v), make only VC (i,v) eligible for o.
REQ-022 SHALL, while input i holds any lock, make only its locked VC eligible in stage 1.
REQ-023 SHALL clear the lock when the locked VC receives a grant with vc_tail=1; out_locked drops on the same registered edge as that grant.
REQ-024 SHALL keep the lock, issuing no grant, while the locked VC deasserts request or out_ready[o]=0.
REQ-025 SHALL not advance pointers while an output or input is locked, except on the tail grant that clears the lock.
REQ-026 SHALL, with LOCK_EN=0, never lock; out_locked held 0.
REQ-027 SHALL guarantee per cycle: at most one grant per input and at most one grant per output.
REQ-028 SHALL ignore requests with target >= OUT_NUM (no grant, no pointer movement).

Reset
REQ-029 SHALL, on RST assertion (asynchronous, any cycle including mid-packet), force vc_grant=0, out_valid=0, out_sel_in=0, out_locked=0, all pointers=0, all locks cleared.
REQ-030 SHALL produce no grant in the first cycle after RST deasserts; the first grant appears 1 cycle after first sampled eligible request.

Verification
REQ-031 SHALL pass: IN=5,VC=2, inputs 0 and 1 VC0 request out 2, tail=1, held 4 cycles -> grants alternate in0,in1,in0,in1; out_sel_in[2]=0,1,0,1.
REQ-032 SHALL pass: in0 VC0 (out1) and VC1 (out3) both request, tail=1 -> one grant per cycle, VC0 then VC1 alternating; never both same cycle.
REQ-033 SHALL pass: in2 VC1 granted out4 with tail=0, in3 VC0 also requests out4 -> out_locked[4]=1, in2 VC1 granted each cycle until tail=1 grant, then in3 granted next cycle.
REQ-034 SHALL pass: locked packet in2->out4, out_ready[4]=0 for 3 cycles -> no grants, out_locked[4] stays 1, resumes with in2 when ready returns.
REQ-035 SHALL pass: RST asserted mid-packet while out_locked[4]=1 -> all outputs 0 immediately; after release in3 request to out4 granted with no lock.
REQ-036 SHALL pass: random requests 10k cycles -> no input or output double grant; every continuously eligible request granted within IN_NUM*VC_NUM grant opportunities of its output.

Source files
------------

// File: rtl/separable_locking_allocator.sv
// Separable input-first allocator with optional packet locking.
// Stage 1 picks one eligible VC per input; stage 2 picks one input per output.
// Both stages are round-robin with iSLIP-style pointer updates. Results are
// registered, so grants appear one cycle after the sampled requests.
module separable_locking_allocator #(
    parameter int IN_NUM  = 5,
    parameter int OUT_NUM = 5,
    parameter int VC_NUM  = 2,
    parameter int LOCK_EN = 1,
    localparam int TW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1,
    localparam int IW = (IN_NUM  > 1) ? $clog2(IN_NUM)  : 1,
    localparam int VW = (VC_NUM  > 1) ? $clog2(VC_NUM)  : 1
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic [IN_NUM*VC_NUM-1:0]     vc_request,
    input  logic [IN_NUM*VC_NUM*TW-1:0]  vc_target_port,
    input  logic [IN_NUM*VC_NUM-1:0]     vc_tail,
    input  logic [OUT_NUM-1:0]           out_ready,
    output logic [IN_NUM*VC_NUM-1:0]     vc_grant,
    output logic [OUT_NUM-1:0]           out_valid,
    output logic [OUT_NUM*IW-1:0]        out_sel_in,
    output logic [OUT_NUM-1:0]           out_locked
);

    // Round-robin helper: (base + k) mod n for base, k < n.
    function automatic int wrap(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? (s - n) : s;
    endfunction

    logic [VW-1:0]             in_ptr_q  [IN_NUM];
    logic [VW-1:0]             in_ptr_d  [IN_NUM];
    logic [IW-1:0]             out_ptr_q [OUT_NUM];
    logic [IW-1:0]             out_ptr_d [OUT_NUM];
    logic [OUT_NUM-1:0]        lk_vld_q, lk_vld_d;
    logic [IW-1:0]             lk_in_q   [OUT_NUM];
    logic [IW-1:0]             lk_in_d   [OUT_NUM];
    logic [VW-1:0]             lk_vc_q   [OUT_NUM];
    logic [VW-1:0]             lk_vc_d   [OUT_NUM];
    logic [IN_NUM*VC_NUM-1:0]  grant_q, grant_d;
    logic [OUT_NUM-1:0]        valid_q, valid_d;
    logic [IW-1:0]             sel_q     [OUT_NUM];
    logic [IW-1:0]             sel_d     [OUT_NUM];

    logic [IN_NUM*VC_NUM-1:0]  elig;
    logic                      in_lk;
    logic [VW-1:0]             in_lk_vc;
    int                        in_lk_out;
    logic [TW-1:0]             tgt;
    logic                      ok;

    logic [IN_NUM-1:0]         s1_vld, s1_tail;
    logic [VW-1:0]             s1_vc  [IN_NUM];
    logic [TW-1:0]             s1_tgt [IN_NUM];

    // Eligibility: valid target, output ready, and no lock blocking the VC.
    // A locked input may only send its locked VC toward its locked output, so
    // one input never holds more than one lock.
    always_comb begin
        elig      = '0;
        in_lk     = 1'b0;
        in_lk_vc  = '0;
        in_lk_out = 0;
        tgt       = '0;
        ok        = 1'b0;
        for (int i = 0; i < IN_NUM; i++) begin
            in_lk     = 1'b0;
            in_lk_vc  = '0;
            in_lk_out = 0;
            for (int o = 0; o < OUT_NUM; o++) begin
                if (lk_vld_q[o] && int'(lk_in_q[o]) == i) begin
                    in_lk     = 1'b1;
                    in_lk_vc  = lk_vc_q[o];
                    in_lk_out = o;
                end
            end
            for (int v = 0; v < VC_NUM; v++) begin
                tgt = vc_target_port[(i*VC_NUM+v)*TW +: TW];
                ok  = 1'b0;
                for (int o = 0; o < OUT_NUM; o++) begin
                    if (int'(tgt) == o)
                        ok = out_ready[o] && (!lk_vld_q[o] ||
                             (int'(lk_in_q[o]) == i && int'(lk_vc_q[o]) == v));
                end
                if (in_lk && (int'(in_lk_vc) != v || int'(tgt) != in_lk_out))
                    ok = 1'b0;
                elig[i*VC_NUM+v] = vc_request[i*VC_NUM+v] && ok;
            end
        end
    end

    // Stage 1: per-input round-robin over eligible VCs starting at in_ptr.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            s1_vld[i]  = 1'b0;
            s1_tail[i] = 1'b0;
            s1_vc[i]   = '0;
            s1_tgt[i]  = '0;
            for (int k = 0; k < VC_NUM; k++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (!s1_vld[i] && v == wrap(int'(in_ptr_q[i]), k, VC_NUM) &&
                        elig[i*VC_NUM+v]) begin
                        s1_vld[i]  = 1'b1;
                        s1_vc[i]   = VW'(v);
                        s1_tgt[i]  = vc_target_port[(i*VC_NUM+v)*TW +: TW];
                        s1_tail[i] = vc_tail[i*VC_NUM+v];
                    end
                end
            end
        end
    end

    // Stage 2: per-output round-robin over stage-1 winners, plus pointer and
    // lock next-state. Body flits of a locked packet leave pointers alone;
    // the head and the tail grant move them.
    always_comb begin
        grant_d  = '0;
        valid_d  = '0;
        lk_vld_d = lk_vld_q;
        for (int i = 0; i < IN_NUM; i++) in_ptr_d[i] = in_ptr_q[i];
        for (int o = 0; o < OUT_NUM; o++) begin
            out_ptr_d[o] = out_ptr_q[o];
            lk_in_d[o]   = lk_in_q[o];
            lk_vc_d[o]   = lk_vc_q[o];
            sel_d[o]     = '0;
        end
        for (int o = 0; o < OUT_NUM; o++) begin
            for (int k = 0; k < IN_NUM; k++) begin
                for (int i = 0; i < IN_NUM; i++) begin
                    if (!valid_d[o] && i == wrap(int'(out_ptr_q[o]), k, IN_NUM) &&
                        s1_vld[i] && int'(s1_tgt[i]) == o) begin
                        valid_d[o] = 1'b1;
                        sel_d[o]   = IW'(i);
                        for (int v = 0; v < VC_NUM; v++)
                            if (int'(s1_vc[i]) == v) grant_d[i*VC_NUM+v] = 1'b1;
                        if (!lk_vld_q[o] || s1_tail[i]) begin
                            out_ptr_d[o] = IW'(wrap(i, 1, IN_NUM));
                            in_ptr_d[i]  = VW'(wrap(int'(s1_vc[i]), 1, VC_NUM));
                        end
                        if (LOCK_EN != 0) begin
                            lk_vld_d[o] = !s1_tail[i];
                            lk_in_d[o]  = IW'(i);
                            lk_vc_d[o]  = s1_vc[i];
                        end
                    end
                end
            end
        end
    end

    // State and registered outputs; reset clears everything, even mid-packet.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            grant_q  <= '0;
            valid_q  <= '0;
            lk_vld_q <= '0;
            for (int i = 0; i < IN_NUM; i++) in_ptr_q[i] <= '0;
            for (int o = 0; o < OUT_NUM; o++) begin
                out_ptr_q[o] <= '0;
                lk_in_q[o]   <= '0;
                lk_vc_q[o]   <= '0;
                sel_q[o]     <= '0;
            end
        end else begin
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            lk_vld_q <= lk_vld_d;
            for (int i = 0; i < IN_NUM; i++) in_ptr_q[i] <= in_ptr_d[i];
            for (int o = 0; o < OUT_NUM; o++) begin
                out_ptr_q[o] <= out_ptr_d[o];
                lk_in_q[o]   <= lk_in_d[o];
                lk_vc_q[o]   <= lk_vc_d[o];
                sel_q[o]     <= sel_d[o];
            end
        end
    end

    assign vc_grant   = grant_q;
    assign out_valid  = valid_q;
    assign out_locked = lk_vld_q;

    // Flatten per-output winner index onto the output bus.
    always_comb begin
        out_sel_in = '0;
        for (int o = 0; o < OUT_NUM; o++) out_sel_in[o*IW +: IW] = sel_q[o];
    end

endmodule
